axi_rr_arb4: RTL and testbench

Four-requester round-robin arbiter that generates the select code for the `MUX_4_1` payload multiplexer in the AXI4 library. It sits directly upstream of the mux.
- It grants one of four valid/ready sources.
- It locks the grant for a whole burst, which ends on the `last` beat.
- It drives `sel[1:0]` so the mux passes the granted source's payload to the downstream port.
- It routes the downstream `ready` back to the granted source only.

Payload data does not pass through this block. It goes through the external `MUX_4_1`, controlled by `sel`.

---
 rtl/axi_rr_arb4.sv | 95 +++++++++
 tb/tb_axi_rr_arb4.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arb4.sv
// Four-source round-robin burst arbiter driving the select of an external 4:1 payload mux; grant one cycle after request.
// Grant is held for the whole burst until a last-beat handshake; ready/valid pass combinationally between the granted source and downstream.
module axi_rr_arb4 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [3:0]       req_valid,
    input  logic [3:0]       req_last,
    output logic [3:0]       req_ready,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pick;
    logic             beat_done;

    // Returns {found, index}; the lowest offset from ptr wins because it is assigned last.
    function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign pick      = rr_pick(req_valid, ptr_q);
    assign busy      = (state_q == S_LOCKED);
    assign grant     = busy ? (4'b0001 << sel_q) : 4'b0000;
    assign m_valid   = busy & req_valid[sel_q];
    assign m_last    = busy & req_last[sel_q];
    assign req_ready = (busy & m_ready) ? grant : 4'b0000;
    assign sel       = sel_q;
    assign beat_cnt  = cnt_q;
    assign beat_done = m_valid & m_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick[2]) begin
                    state_d = S_LOCKED;
                    sel_d   = pick[1:0];
                    cnt_d   = '0;
                end
            end
            S_LOCKED: begin
                if (beat_done) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    // The finishing source drops to lowest priority.
                    if (m_last) begin
                        state_d = S_IDLE;
                        ptr_d   = sel_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_rr_arb4.sv
// Directed bench for axi_rr_arb4: inputs change 1 ns after each rising edge, outputs are checked right after.
module tb_axi_rr_arb4;

    logic       clk;
    logic       resetn;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic [7:0] beat_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_src;

    axi_rr_arb4 #(.CNT_W(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .sel       (sel),
        .grant     (grant),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two edges with all sources requesting
        resetn    = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b0000;
        m_ready   = 1'b0;
        tick();
        chk("rst1_grant", grant, 4'b0000);
        chk("rst1_sel", sel, 2'd0);
        chk("rst1_ready", req_ready, 4'b0000);
        chk("rst1_busy", busy, 1'b0);
        chk("rst1_mlast", m_last, 1'b0);
        tick();
        chk("rst2_grant", grant, 4'b0000);
        chk("rst2_mvalid", m_valid, 1'b0);
        resetn = 1'b1;
        #1;
        chk("rel_grant0", grant, 4'b0000);
        tick();
        chk("rel_grant1", grant, 4'b0001);
        chk("rel_sel", sel, 2'd0);
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        m_ready   = 1'b1;
        #1;
        chk("rel_ready", req_ready, 4'b0001);
        tick();
        chk("rel_idle", busy, 1'b0);
        chk("rel_ptr", dut.ptr_q, 2'd1);
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        tick();

        // Single 3-beat burst from source 2 (ptr=1)
        req_valid = 4'b0100;
        tick();
        chk("sb_sel", sel, 2'd2);
        chk("sb_grant", grant, 4'b0100);
        chk("sb_ready0", req_ready, 4'b0100);
        chk("sb_cnt0", beat_cnt, 8'd0);
        tick();
        chk("sb_ready1", req_ready, 4'b0100);
        chk("sb_cnt1", beat_cnt, 8'd1);
        tick();
        req_last = 4'b0100;
        #1;
        chk("sb_ready2", req_ready, 4'b0100);
        chk("sb_cnt2", beat_cnt, 8'd2);
        chk("sb_mlast", m_last, 1'b1);
        tick();
        req_valid = 4'b0000;
        req_last  = 4'b0100;
        #1;
        chk("sb_idle", busy, 1'b0);
        chk("sb_idle_mlast", m_last, 1'b0);
        chk("sb_ptr", dut.ptr_q, 2'd3);
        req_last = 4'b0000;

        // Round robin with 1-beat bursts from all sources, starting at ptr=3
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        m_ready   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_src = (3 + k) % 4;
            tick();
            chk("rr_grant", grant, 4'b0001 << exp_src);
            chk("rr_sel", sel, exp_src);
            tick();
            chk("rr_gap", grant, 4'b0000);
        end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        #1;
        chk("rr_ptr", dut.ptr_q, 2'd1);

        // Backpressure on a 2-beat burst from source 1
        req_valid = 4'b0010;
        tick();
        chk("bp_sel0", sel, 2'd1);
        chk("bp_ready0", req_ready, 4'b0010);
        chk("bp_cnt0", beat_cnt, 8'd0);
        tick();
        m_ready  = 1'b0;
        req_last = 4'b0010;
        #1;
        chk("bp_ready1", req_ready, 4'b0000);
        chk("bp_cnt1", beat_cnt, 8'd1);
        tick();
        chk("bp_ready2", req_ready, 4'b0000);
        chk("bp_cnt2", beat_cnt, 8'd1);
        chk("bp_sel2", sel, 2'd1);
        m_ready = 1'b1;
        #1;
        chk("bp_ready3", req_ready, 4'b0010);
        chk("bp_sel3", sel, 2'd1);
        tick();
        chk("bp_idle", busy, 1'b0);
        chk("bp_cnt_end", beat_cnt, 8'd2);
        chk("bp_ptr", dut.ptr_q, 2'd2);
        req_valid = 4'b0000;
        req_last  = 4'b0000;

        // No preemption: source 0 locked, source 3 arrives, source 0 drops valid
        req_valid = 4'b0001;
        tick();
        chk("np_grant0", grant, 4'b0001);
        tick();
        req_valid = 4'b1000;
        #1;
        chk("np_grant1", grant, 4'b0001);
        chk("np_mvalid1", m_valid, 1'b0);
        chk("np_cnt1", beat_cnt, 8'd1);
        tick();
        chk("np_grant2", grant, 4'b0001);
        chk("np_mvalid2", m_valid, 1'b0);
        chk("np_cnt2", beat_cnt, 8'd1);
        req_valid = 4'b1001;
        req_last  = 4'b0001;
        #1;
        chk("np_mlast", m_last, 1'b1);
        tick();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        #1;
        chk("np_rel_idle", grant, 4'b0000);
        tick();
        chk("np_grant3", grant, 4'b1000);
        req_last = 4'b1000;
        tick();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        #1;
        chk("np_ptr", dut.ptr_q, 2'd0);

        // Reset during beat 2 of a 4-beat burst from source 1
        req_valid = 4'b0010;
        tick();
        chk("mr_grant0", grant, 4'b0010);
        tick();
        chk("mr_cnt1", beat_cnt, 8'd1);
        resetn = 1'b0;
        tick();
        chk("mr_grant", grant, 4'b0000);
        chk("mr_sel", sel, 2'd0);
        chk("mr_ptr", dut.ptr_q, 2'd0);
        chk("mr_cnt", beat_cnt, 8'd0);
        chk("mr_ready", req_ready, 4'b0000);
        resetn    = 1'b1;
        req_valid = 4'b0011;
        tick();
        chk("mr_restart_grant", grant, 4'b0001);
        chk("mr_restart_sel", sel, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
